// File: rtl/mycpu_data_bridge_pkg.sv
// rtl/mycpu_data_bridge_pkg.sv - shared state encodings and bus size codes for the data bridge
package mycpu_data_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } bridge_state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mycpu_data_bridge_size_dec.sv
// rtl/mycpu_data_bridge_size_dec.sv - byte-enable to bus size/offset decode for stores
module data_size_dec
   import mycpu_data_bridge_pkg::*;
(
   input  logic [3:0] wen,
   output logic [1:0] size,
   output logic [1:0] offset
);

   // Unsupported enable patterns fall back to an aligned word store.
   always_comb begin
      size   = SIZE_WORD;
      offset = 2'd0;
      case (wen)
         4'b0011: begin size = SIZE_HALF; offset = 2'd0; end
         4'b1100: begin size = SIZE_HALF; offset = 2'd2; end
         4'b0001: begin size = SIZE_BYTE; offset = 2'd0; end
         4'b0010: begin size = SIZE_BYTE; offset = 2'd1; end
         4'b0100: begin size = SIZE_BYTE; offset = 2'd2; end
         4'b1000: begin size = SIZE_BYTE; offset = 2'd3; end
         default: begin size = SIZE_WORD; offset = 2'd0; end
      endcase
   end

endmodule

// File: rtl/mycpu_data_bridge.sv
// rtl/mycpu_data_bridge.sv - core data port to SRAM-like bus bridge, one access outstanding
module mycpu_data_bridge
   import mycpu_data_bridge_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          core_en,
   input  logic [3:0]    core_wen,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          stallreq,
   output logic          data_req,
   output logic          data_wr,
   output logic [1:0]    data_size,
   output logic [AW-1:0] data_addr,
   output logic [DW-1:0] data_wdata,
   input  logic          data_addr_ok,
   input  logic          data_data_ok,
   input  logic [DW-1:0] data_rdata
);

   bridge_state_t state;
   logic          req_wr;
   logic [1:0]    req_size;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [DW-1:0] rbuf;
   logic [1:0]    dec_size;
   logic [1:0]    dec_offset;
   logic          is_wr;
   logic          unused_addr_lsb;

   assign is_wr           = |core_wen;
   assign unused_addr_lsb = ^core_addr[1:0];

   data_size_dec u_size_dec (
      .wen    (core_wen),
      .size   (dec_size),
      .offset (dec_offset)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         data_req  <= 1'b0;
         req_wr    <= 1'b0;
         req_size  <= 2'd0;
         req_addr  <= '0;
         req_wdata <= '0;
         rbuf      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (core_en) begin
                  req_wr    <= is_wr;
                  req_size  <= is_wr ? dec_size : SIZE_WORD;
                  req_addr  <= {core_addr[AW-1:2], (is_wr ? dec_offset : 2'd0)};
                  req_wdata <= core_wdata;
                  data_req  <= 1'b1;
                  state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (data_addr_ok) begin
                  data_req <= 1'b0;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (data_data_ok) begin
                  if (!req_wr) rbuf <= data_rdata;
                  state <= ST_DONE;
               end
            end
            // core_en is still high here for the retiring access; never restart from DONE.
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign stallreq   = resetn & ((state == ST_REQ) | (state == ST_WAIT) |
                                 ((state == ST_IDLE) & core_en));
   assign data_wr    = req_wr;
   assign data_size  = req_size;
   assign data_addr  = req_addr;
   assign data_wdata = req_wdata;
   assign core_rdata = rbuf;

endmodule

// File: tb/tb_mycpu_data_bridge.sv
// tb/tb_mycpu_data_bridge.sv - randomized scoreboard bench for mycpu_data_bridge
module tb_mycpu_data_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        core_en;
   logic [3:0]  core_wen;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        stallreq;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   always #5 clk = ~clk;

   mycpu_data_bridge #(.AW(32), .DW(32)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .core_en      (core_en),
      .core_wen     (core_wen),
      .core_addr    (core_addr),
      .core_wdata   (core_wdata),
      .core_rdata   (core_rdata),
      .stallreq     (stallreq),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_req_t;

   typedef struct {
      int          addr_dly;
      int          data_dly;
      logic [31:0] rdata;
   } resp_t;

   bus_req_t    exp_req_q[$];
   resp_t       resp_q[$];
   int          exp_stall_q[$];
   logic [31:0] exp_rd_q[$];

   int          total = 0;
   int          bad = 0;
   int          issued = 0;
   int          txn_seen = 0;
   bit          manual = 1'b0;
   bit          abort = 1'b0;
   logic [31:0] model_buf = 32'h0;
   logic        m_aok = 1'b0;
   logic        m_dok = 1'b0;
   logic [31:0] m_rd = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // Reference: what the bus should see for a core access.
   function automatic bus_req_t model_req(input logic [3:0] wen, input logic [31:0] addr,
                                          input logic [31:0] wdata);
      bus_req_t r;
      r.wr    = (wen != 4'b0000);
      r.wdata = wdata;
      r.size  = 2'd2;
      r.addr  = addr & 32'hFFFF_FFFC;
      if (r.wr) begin
         if (wen == 4'b0011) r.size = 2'd1;
         else if (wen == 4'b1100) begin
            r.size = 2'd1;
            r.addr = r.addr + 32'd2;
         end else if ($countones(wen) == 1) begin
            r.size = 2'd0;
            for (int b = 0; b < 4; b++) if (wen[b]) r.addr = r.addr + 32'(b);
         end
      end
      return r;
   endfunction

   // Bus responder: checks each issued request and answers with scripted delays.
   initial begin
      bus_req_t e;
      resp_t    rs;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'h0;
      forever begin
         @(negedge clk);
         if (manual) begin
            data_addr_ok = m_aok;
            data_data_ok = m_dok;
            data_rdata   = m_rd;
            continue;
         end
         if (!data_req) begin
            data_addr_ok = 1'($urandom);
            data_data_ok = 1'($urandom);
            data_rdata   = $urandom;
            continue;
         end
         txn_seen++;
         if (exp_req_q.size() == 0 || resp_q.size() == 0) begin
            check("unexpected_req", 32'(data_req), 32'd0);
            data_addr_ok = 1'b1;
            continue;
         end
         e  = exp_req_q.pop_front();
         rs = resp_q.pop_front();
         check("req_wr", 32'(data_wr), 32'(e.wr));
         check("req_size", 32'(data_size), 32'(e.size));
         check("req_addr", data_addr, e.addr);
         if (e.wr) check("req_wdata", data_wdata, e.wdata);
         data_addr_ok = 1'b0;
         for (int i = 0; i < rs.addr_dly; i++) begin
            data_data_ok = 1'($urandom);
            @(negedge clk);
            check("req_held", 32'(data_req), 32'd1);
            check("req_addr_stable", data_addr, e.addr);
            check("req_size_stable", 32'(data_size), 32'(e.size));
            if (e.wr) check("req_wdata_stable", data_wdata, e.wdata);
         end
         data_addr_ok = 1'b1;
         data_data_ok = 1'($urandom);
         @(negedge clk);
         check("req_low_wait", 32'(data_req), 32'd0);
         data_data_ok = 1'b0;
         for (int i = 0; i < rs.data_dly; i++) begin
            data_addr_ok = 1'($urandom);
            @(negedge clk);
            check("req_low_wait", 32'(data_req), 32'd0);
         end
         data_addr_ok = 1'($urandom);
         data_data_ok = 1'b1;
         data_rdata   = rs.rdata;
         @(negedge clk);
         check("req_low_done", 32'(data_req), 32'd0);
         data_addr_ok = 1'b0;
         data_data_ok = 1'($urandom);
         data_rdata   = $urandom;
      end
   end

   // Monitor: stall-window length per access and the returned load data.
   initial begin
      int          cnt;
      logic [31:0] cur;
      cnt = 0;
      cur = 32'h0;
      forever begin
         @(negedge clk);
         if (manual || !resetn) begin
            cnt = 0;
            continue;
         end
         if (stallreq) cnt++;
         else begin
            if (cnt > 0) begin
               if (exp_stall_q.size() == 0 || exp_rd_q.size() == 0) begin
                  check("unexpected_stall", 32'(cnt), 32'd0);
               end else begin
                  check("stall_cycles", 32'(cnt), 32'(exp_stall_q.pop_front()));
                  cur = exp_rd_q.pop_front();
               end
               cnt = 0;
            end
            check("core_rdata", core_rdata, cur);
         end
      end
   end

   task automatic run_txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int adly, input int ddly, input int gap);
      resp_t rs;
      bit    done;
      if (abort) return;
      @(posedge clk);
      #1;
      if (gap > 0) begin
         core_en = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      rs.addr_dly = adly;
      rs.data_dly = ddly;
      rs.rdata    = rdata;
      exp_req_q.push_back(model_req(wen, addr, wdata));
      resp_q.push_back(rs);
      exp_stall_q.push_back(adly + ddly + 3);
      if (wen == 4'b0000) model_buf = rdata;
      exp_rd_q.push_back(model_buf);
      issued++;
      core_en    = 1'b1;
      core_wen   = wen;
      core_addr  = addr;
      core_wdata = wdata;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (c > 0 && !stallreq) done = 1'b1;
      end
      if (!done) begin
         check("txn_timeout", 32'd1, 32'd0);
         abort = 1'b1;
      end
   endtask

   initial begin
      resetn     = 1'b0;
      core_en    = 1'b1;
      core_wen   = 4'b0000;
      core_addr  = 32'h0;
      core_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stallreq", 32'(stallreq), 32'd0);
      check("rst_data_req", 32'(data_req), 32'd0);
      check("rst_core_rdata", core_rdata, 32'h0);
      check("rst_data_addr", data_addr, 32'h0);
      check("rst_data_size", 32'(data_size), 32'd0);
      core_en = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;

      run_txn(4'b0000, 32'h8000_0006, 32'h0, 32'hDEAD_BEEF, 0, 0, 1);
      run_txn(4'b0100, 32'h0000_0010, 32'h00AB_0000, 32'h0BAD_0BAD, 0, 0, 2);
      run_txn(4'b0000, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 3, 0, 1);
      run_txn(4'b0000, 32'h0000_0000, 32'h0, 32'h1111_1111, 0, 0, 1);
      run_txn(4'b0000, 32'h0000_0004, 32'h0, 32'h2222_2222, 0, 0, 0);
      run_txn(4'b1100, 32'h0000_0020, 32'h5A5A_0000, 32'h0, 0, 2, 1);
      for (int n = 0; n < 40; n++) begin
         logic [3:0] w;
         w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
         run_txn(w, $urandom, $urandom, $urandom, int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
      end
      run_txn(4'b0000, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 0, 1);

      @(posedge clk);
      #1;
      core_en = 1'b0;
      repeat (5) @(posedge clk);
      check("txn_count", 32'(txn_seen), 32'(issued));

      // Reset during WAIT, then a stray data_ok after release.
      #1;
      manual     = 1'b1;
      m_aok      = 1'b0;
      m_dok      = 1'b0;
      m_rd       = 32'h5555_AAAA;
      core_en    = 1'b1;
      core_wen   = 4'b0000;
      core_addr  = 32'h0000_0200;
      @(posedge clk);
      #1;
      m_aok = 1'b1;
      @(posedge clk);
      #1;
      m_aok = 1'b0;
      check("wait_stallreq", 32'(stallreq), 32'd1);
      check("wait_data_req", 32'(data_req), 32'd0);
      resetn = 1'b0;
      #1;
      check("midrst_stallreq", 32'(stallreq), 32'd0);
      check("midrst_data_req", 32'(data_req), 32'd0);
      check("midrst_core_rdata", core_rdata, 32'h0);
      @(posedge clk);
      #1;
      resetn  = 1'b1;
      core_en = 1'b0;
      m_dok   = 1'b1;
      @(posedge clk);
      #1;
      m_dok = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_stallreq", 32'(stallreq), 32'd0);
         check("post_rst_data_req", 32'(data_req), 32'd0);
         check("post_rst_core_rdata", core_rdata, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mycpu_data_bridge.md
MYCPU_DATA_BRIDGE -- requirements
Module: mycpu_data_bridge

Interface
REQ-001 The block SHALL have parameter AW, default 32, the address width.
REQ-002 The block SHALL have parameter DW, default 32, the data width.
REQ-003 The block SHALL have one clock, clk: input, 1 bit, all state on the rising edge.
REQ-004 The block SHALL have one reset, resetn: input, 1 bit, asynchronous, active-low.
REQ-005 core_en  input  1  core data access request, held stable while stallreq=1.
REQ-006 core_wen  input  4  byte write enables; 0 means read.
REQ-007 core_addr  input  AW  byte address from the core.
REQ-008 core_wdata  input  DW  store data, already byte-lane aligned.
REQ-009 core_rdata  output  DW  load data returned to the core's MEM stage.
REQ-010 stallreq  output  1  freezes the pipeline while an access is outstanding.
REQ-011 data_req  output  1  SRAM-like bus request.
REQ-012 data_wr  output  1  1 = write.
REQ-013 data_size  output  2  0 = byte, 1 = half, 2 = word.
REQ-014 data_addr  output  AW  bus address.
REQ-015 data_wdata  output  DW  bus write data.
REQ-016 data_addr_ok  input  1  request accepted.
REQ-017 data_data_ok  input  1  read data valid or write complete.
REQ-018 data_rdata  input  DW  bus read data.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-020 In IDLE with core_en=1, the block SHALL register wr=|core_wen, size, addr and wdata, then go to REQ.
REQ-021 stallreq SHALL be 1 in REQ and WAIT, and 1 in IDLE when core_en=1 (combinational), so the pipeline freezes in the request cycle itself.
REQ-022 stallreq SHALL be 0 in DONE and in IDLE when core_en=0.
REQ-023 In REQ, data_req SHALL be 1 with the registered fields; on data_addr_ok=1 the FSM SHALL go to WAIT, otherwise stay in REQ with all fields stable.
REQ-024 data_req SHALL be 0 in IDLE, WAIT and DONE; at most one transaction SHALL be outstanding.
REQ-025 In WAIT, on data_data_ok=1 the block SHALL capture data_rdata into the read buffer (reads only) and go to DONE.
REQ-026 In DONE the FSM SHALL go to IDLE unconditionally; core_en seen in DONE is the same, now-retiring access and SHALL be ignored.
REQ-027 core_rdata SHALL always equal the read buffer, held until the next read's data_data_ok, because the core consumes it one cycle after DONE.
REQ-028 Minimum latency SHALL be 3 stall cycles (IDLE-detect, REQ with addr_ok, WAIT with data_ok), then DONE.
REQ-029 Read requests SHALL use size=2 and addr = core_addr with bits[1:0] cleared; byte selection stays in the core.
REQ-030 Write size/offset decode SHALL be:
- 1111 -> size 2, offset 0
- 0011 -> size 1, offset 0
- 1100 -> size 1, offset 2
- 0001/0010/0100/1000 -> size 0, offset 0/1/2/3
REQ-031 For writes, data_addr SHALL be {core_addr[AW-1:2], offset}.
REQ-032 Any other write enable pattern SHALL be treated as a word write at the aligned address.
REQ-033 data_data_ok in IDLE, REQ or DONE SHALL be ignored without state change.
REQ-034 data_addr_ok outside REQ SHALL be ignored.

Reset
REQ-035 When resetn=0, the block SHALL asynchronously force state=IDLE, data_req=0, the registered request fields to 0 and the read buffer to 0.
REQ-036 Reset in any state, including mid-transaction, SHALL abandon the transaction; a late data_data_ok after release SHALL be ignored per REQ-033.
REQ-037 While resetn=0, stallreq SHALL be 0 regardless of core_en.

Structure
REQ-038 State encodings and the size codes (byte/half/word) SHALL live in the shared defines header alongside the existing bus-width macros.
REQ-039 The wen-to-{size, offset} decode SHALL be a combinational sub-module named data_size_dec.
REQ-040 The bridge SHALL be instantiated in the top wrapper between the core's data_sram_* ports and the bus.
REQ-041 stallreq SHALL be ORed into CTRL's stall request input.

Verification
REQ-042 Word read, addr_ok on the first REQ cycle, data_ok one cycle later with rdata=0xDEADBEEF, core_addr=0x80000006 -> data_addr=0x80000004, size=2, wr=0; stallreq high exactly 3 cycles; core_rdata=0xDEADBEEF in DONE and the following cycle.
REQ-043 Byte write, wen=0100, addr=0x10, wdata=0x00AB0000 -> data_addr=0x12, size=0, wr=1, data_wdata=0x00AB0000; core_rdata unchanged.
REQ-044 addr_ok delayed 4 cycles -> data_req held 4 cycles with stable addr/size/wdata; stallreq high 6 cycles total.
REQ-045 Back-to-back reads to 0x0 (0x11111111) then 0x4 (0x22222222), core_en continuous -> two transactions only, none issued from DONE; core_rdata updates once per read.
REQ-046 resetn pulsed low during WAIT, then data_data_ok arrives -> state IDLE, data_req=0, stallreq=0, buffer=0; the stray data_ok is ignored.
REQ-047 Halfword write, wen=1100, addr=0x20 -> data_addr=0x22, size=1; a spurious data_addr_ok during WAIT causes no state change.
